// File: rtl/trans_conv_upsample_pad.sv
// Streaming zero-insertion + zero-padding front end for transposed convolution.
// Emits an OUT_H x OUT_W raster frame per IN_HEIGHT x IN_WIDTH input frame.
module trans_conv_upsample_pad #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IN_WIDTH   = 7,
  parameter int unsigned IN_HEIGHT  = 7,
  parameter int unsigned STRIDE     = 2,
  parameter int unsigned PAD_TOP    = 1,
  parameter int unsigned PAD_BOTTOM = 2,
  parameter int unsigned PAD_LEFT   = 1,
  parameter int unsigned PAD_RIGHT  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         ready_out,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         sof_out,
  output logic                         eof_out,
  input  logic                         ready_in
);

  localparam int unsigned UP_W  = IN_WIDTH * STRIDE;
  localparam int unsigned UP_H  = IN_HEIGHT * STRIDE;
  localparam int unsigned OUT_W = UP_W + PAD_LEFT + PAD_RIGHT;
  localparam int unsigned OUT_H = UP_H + PAD_TOP + PAD_BOTTOM;
  localparam int unsigned ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic [ROW_W-1:0] row_cnt, row_nxt;
  logic [COL_W-1:0] col_cnt, col_nxt;
  logic [PH_W-1:0]  row_ph, row_ph_nxt;
  logic [PH_W-1:0]  col_ph, col_ph_nxt;
  logic             row_act, col_act, row_last, col_last;
  logic             at_data, at_first, at_last, ld, advance;

  // Position decode: phases are zero exactly on the non-inserted samples
  assign row_act  = (32'(row_cnt) >= PAD_TOP) && (32'(row_cnt) < PAD_TOP + UP_H);
  assign col_act  = (32'(col_cnt) >= PAD_LEFT) && (32'(col_cnt) < PAD_LEFT + UP_W);
  assign row_last = (32'(row_cnt) == OUT_H - 1);
  assign col_last = (32'(col_cnt) == OUT_W - 1);
  assign at_data  = row_act && col_act && (row_ph == '0) && (col_ph == '0);
  assign at_first = (row_cnt == '0) && (col_cnt == '0);
  assign at_last  = row_last && col_last;

  assign ld        = !valid_out || ready_in;
  assign advance   = ld && (!at_data || valid_in);
  assign ready_out = !rst && ld && at_data;

  // Next raster position; phases restart when the unpadded region is entered
  always_comb begin
    row_nxt    = row_cnt;
    col_nxt    = col_cnt;
    row_ph_nxt = row_ph;
    col_ph_nxt = col_ph;
    if (col_last) begin
      col_nxt    = '0;
      col_ph_nxt = '0;
      if (row_last) begin
        row_nxt    = '0;
        row_ph_nxt = '0;
      end else begin
        row_nxt = row_cnt + ROW_W'(1);
        if ((32'(row_cnt) + 32'd1 == PAD_TOP) || (row_ph == PH_W'(STRIDE - 1)))
          row_ph_nxt = '0;
        else
          row_ph_nxt = row_ph + PH_W'(1);
      end
    end else begin
      col_nxt = col_cnt + COL_W'(1);
      if ((32'(col_cnt) + 32'd1 == PAD_LEFT) || (col_ph == PH_W'(STRIDE - 1)))
        col_ph_nxt = '0;
      else
        col_ph_nxt = col_ph + PH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt <= '0;
      col_cnt <= '0;
      row_ph  <= '0;
      col_ph  <= '0;
    end else if (advance) begin
      row_cnt <= row_nxt;
      col_cnt <= col_nxt;
      row_ph  <= row_ph_nxt;
      col_ph  <= col_ph_nxt;
    end
  end

  // Output register: loads on advance, drains to a bubble on an upstream stall
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      sof_out   <= 1'b0;
      eof_out   <= 1'b0;
    end else if (advance) begin
      valid_out <= 1'b1;
      data_out  <= at_data ? data_in : '0;
      sof_out   <= at_first;
      eof_out   <= at_last;
    end else if (ld) begin
      valid_out <= 1'b0;
    end
  end

endmodule
